stack_queue_ctrl: RTL and testbench

Sequencing controller for the team's stack/queue storage. It owns the read, write and stack pointers and the occupancy count, and accepts push, pop and flush requests through a ready/request handshake. It drives one-cycle write and read strobes with addresses into the shared memory array, and reports FULL, EMPTY, COUNT and error status. One latched mode bit selects LIFO (stack) or FIFO (queue) behaviour over the same storage.

---
 rtl/stack_queue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stack_queue_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_queue_ctrl.sv
// stack_queue_ctrl: pointer/count sequencer for a shared 2^AW-entry store.
// One latched mode bit selects LIFO (stack) or FIFO (queue) use of the same
// storage. Requests are taken only in IDLE; each accepted op drives one-cycle
// write/read strobes and ends with a one-cycle DONE pulse. Rejected requests
// end with a one-cycle ERR pulse and leave all pointers and the count alone.
//
// Handshake: READY=1 exactly when the FSM is in IDLE. PUSH/POP/FLUSH are
// sampled on a rising edge only if READY was 1 in the cycle before that edge.
// Values on them in any other cycle are ignored.
module stack_queue_ctrl #(
    parameter int AW = 3
) (
    input  logic          CLK,
    input  logic          Clr,
    input  logic          MODE,
    input  logic          PUSH,
    input  logic          POP,
    input  logic          FLUSH,
    output logic          READY,
    output logic          WE,
    output logic [AW-1:0] WADDR,
    output logic          RE,
    output logic [AW-1:0] RADDR,
    output logic          DONE,
    output logic          ERR,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   COUNT,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPW  = 2'd1,
        OPR  = 2'd2,
        OPRW = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ONE_C = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_P = {{(AW-1){1'b0}}, 1'b1};

    state_t        state, state_n;
    logic [AW-1:0] wp, wp_n;
    logic [AW-1:0] rp, rp_n;
    logic [AW:0]   count, count_n;
    logic [AW:0]   count_m1;
    logic          mq, mq_n;
    logic          pair, pair_n;     // current OPW is the write half of a combined op
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic          full_q, empty_q;

    // State register; Clr wins over everything and drops any in-flight op.
    always_ff @(posedge CLK) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers; FULL/EMPTY are derived from the next count so they
    // always agree with COUNT in the same cycle.
    always_ff @(posedge CLK) begin
        if (Clr) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            mq      <= 1'b0;
            pair    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wp      <= wp_n;
            rp      <= rp_n;
            count   <= count_n;
            mq      <= mq_n;
            pair    <= pair_n;
            done_q  <= done_n;
            err_q   <= err_n;
            full_q  <= (count_n == DEPTH);
            empty_q <= (count_n == '0);
        end
    end

    // Next-state and next-register decode: request priority in IDLE, commit in op states.
    always_comb begin
        state_n = state;
        wp_n    = wp;
        rp_n    = rp;
        count_n = count;
        mq_n    = mq;
        pair_n  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (FLUSH) begin
                    wp_n    = '0;
                    rp_n    = '0;
                    count_n = '0;
                    done_n  = 1'b1;
                end else if (PUSH || POP) begin
                    if ((MODE != mq) && (count != '0)) begin
                        // Mode may only change while the store is empty.
                        err_n = 1'b1;
                    end else begin
                        mq_n = MODE;
                        if (PUSH && !POP) begin
                            if (count == DEPTH) err_n = 1'b1;
                            else                state_n = OPW;
                        end else if (POP && !PUSH) begin
                            if (count == '0) err_n = 1'b1;
                            else             state_n = OPR;
                        end else begin
                            // Combined op only makes sense for a non-empty queue.
                            if (!MODE || (count == '0)) err_n = 1'b1;
                            else                        state_n = OPRW;
                        end
                    end
                end
            end
            OPW: begin
                if (!pair) begin
                    count_n = count + ONE_C;
                end
                if (mq) begin
                    wp_n = wp + ONE_P;
                end
                done_n  = 1'b1;
                state_n = IDLE;
            end
            OPR: begin
                count_n = count - ONE_C;
                if (mq) begin
                    rp_n = rp + ONE_P;
                end
                done_n  = 1'b1;
                state_n = IDLE;
            end
            OPRW: begin
                // Read frees a slot first, so the write that follows is legal even when full.
                rp_n    = rp + ONE_P;
                pair_n  = 1'b1;
                state_n = OPW;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Strobes and addresses; strobes are suppressed in a cycle where Clr is high.
    always_comb begin
        count_m1  = count - ONE_C;
        READY     = (state == IDLE);
        WE        = (state == OPW) && !Clr;
        RE        = ((state == OPR) || (state == OPRW)) && !Clr;
        WADDR     = mq ? wp : count[AW-1:0];
        RADDR     = mq ? rp : count_m1[AW-1:0];
        DONE      = done_q;
        ERR       = err_q;
        FULL      = full_q;
        EMPTY     = empty_q;
        COUNT     = count;
        dbg_state = state;
    end

endmodule

// File: tb/tb_stack_queue_ctrl.sv
// Bench for stack_queue_ctrl (AW=3): table of requests with expected event
// streams, a negedge monitor feeding a scoreboard queue, and hand sequences
// for the combined queue op and Clr during an op.
module tb_stack_queue_ctrl;

    localparam int AW = 3;
    localparam int W  = 6;

    logic          CLK = 1'b0;
    logic          Clr = 1'b1;
    logic          MODE = 1'b0, PUSH = 1'b0, POP = 1'b0, FLUSH = 1'b0;
    logic          READY, WE, RE, DONE, ERR, FULL, EMPTY;
    logic [AW-1:0] WADDR, RADDR;
    logic [AW:0]   COUNT;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic             push, pop, flush, mode;
        int               n;
        logic [2:0][W-1:0] e;
    } vec_t;
    vec_t vt[$];

    stack_queue_ctrl #(.AW(AW)) dut (
        .CLK(CLK), .Clr(Clr), .MODE(MODE), .PUSH(PUSH), .POP(POP), .FLUSH(FLUSH),
        .READY(READY), .WE(WE), .WADDR(WADDR), .RE(RE), .RADDR(RADDR),
        .DONE(DONE), .ERR(ERR), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
        .dbg_state(dbg_state)
    );

    // clock / reset / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // event kinds: 0=write(addr) 1=read(addr) 2=done(count) 3=err(count)
    function automatic logic [W-1:0] ev(input int k, input int v);
        logic [1:0] kk;
        logic [3:0] vv;
        kk = 2'(k);
        vv = 4'(v);
        return {kk, vv};
    endfunction

    function automatic vec_t mk(input logic pu, po, fl, md, input int n,
                                input logic [W-1:0] e0, e1, e2);
        vec_t v;
        v.push = pu; v.pop = po; v.flush = fl; v.mode = md; v.n = n;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
        return v;
    endfunction

    task automatic got(input logic [W-1:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got event %0h expected none at %0t", act, $time);
        end else begin
            chk("sb_event", act, exp_q.pop_front());
        end
    endtask

    // monitor: invariants plus strobe/pulse events into the scoreboard
    always @(negedge CLK) begin
        if (mon_en && !Clr) begin
            chk("we_re_excl", WE & RE, 0);
            chk("done_err_excl", DONE & ERR, 0);
            chk("full_flag", FULL, COUNT == 8);
            chk("empty_flag", EMPTY, COUNT == 0);
            if (WE)   got(ev(0, WADDR));
            if (RE)   got(ev(1, RADDR));
            if (DONE) got(ev(2, COUNT));
            if (ERR)  got(ev(3, COUNT));
        end
    end

    // driver tasks
    task automatic issue(input logic pu, po, fl, md);
        int t = 0;
        @(posedge CLK); #2;
        while (!READY && t < 20) begin
            @(posedge CLK); #2;
            t++;
        end
        chk("ready_timeout", READY, 1);
        PUSH = pu; POP = po; FLUSH = fl; MODE = md;
        @(posedge CLK); #2;
        PUSH = 0; POP = 0; FLUSH = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge CLK);
            t++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        // stack fill / drain
        for (int i = 0; i < 8; i++) vt.push_back(mk(1, 0, 0, 0, 2, ev(0, i), ev(2, i + 1), 0));
        vt.push_back(mk(1, 0, 0, 0, 1, ev(3, 8), 0, 0));
        for (int i = 7; i >= 0; i--) vt.push_back(mk(0, 1, 0, 0, 2, ev(1, i), ev(2, i), 0));
        vt.push_back(mk(0, 1, 0, 0, 1, ev(3, 0), 0, 0));
        // stack combined op is illegal; mode change with data is illegal
        for (int i = 0; i < 3; i++) vt.push_back(mk(1, 0, 0, 0, 2, ev(0, i), ev(2, i + 1), 0));
        vt.push_back(mk(1, 1, 0, 0, 1, ev(3, 3), 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 1, ev(3, 3), 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 2, ev(1, 2), ev(2, 2), 0));
        vt.push_back(mk(0, 0, 1, 0, 1, ev(2, 0), 0, 0));
        // queue after flush: push 6, pop 6, push 5 (wraps), pop 5
        for (int i = 0; i < 6; i++) vt.push_back(mk(1, 0, 0, 1, 2, ev(0, i), ev(2, i + 1), 0));
        for (int i = 0; i < 6; i++) vt.push_back(mk(0, 1, 0, 1, 2, ev(1, i), ev(2, 5 - i), 0));
        for (int i = 0; i < 5; i++) vt.push_back(mk(1, 0, 0, 1, 2, ev(0, (6 + i) % 8), ev(2, i + 1), 0));
        for (int i = 0; i < 5; i++) vt.push_back(mk(0, 1, 0, 1, 2, ev(1, (6 + i) % 8), ev(2, 4 - i), 0));
        vt.push_back(mk(1, 1, 0, 1, 1, ev(3, 0), 0, 0));
        // fill queue from wp=3
        for (int i = 0; i < 8; i++) vt.push_back(mk(1, 0, 0, 1, 2, ev(0, (3 + i) % 8), ev(2, i + 1), 0));
        vt.push_back(mk(1, 0, 0, 1, 1, ev(3, 8), 0, 0));

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("clr_we", WE, 0);
        chk("clr_re", RE, 0);
        #2 Clr = 0;
        @(negedge CLK);
        chk("rst_ready", READY, 1);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_strobes", {WE, RE}, 0);
        mon_en = 1;

        // table-driven vectors
        foreach (vt[i]) begin
            for (int j = 0; j < vt[i].n; j++) exp_q.push_back(vt[i].e[j]);
            issue(vt[i].push, vt[i].pop, vt[i].flush, vt[i].mode);
            drain();
        end
        chk("full_at_8", FULL, 1);

        // combined queue op while full: RE at k, WE at k+1, DONE at k+2
        exp_q.push_back(ev(1, 3));
        exp_q.push_back(ev(0, 3));
        exp_q.push_back(ev(2, 8));
        @(posedge CLK); #2;
        chk("rw_ready", READY, 1);
        PUSH = 1; POP = 1; MODE = 1;
        @(posedge CLK); #2;
        PUSH = 0; POP = 0;
        @(negedge CLK);
        chk("rw_k_re", RE, 1);
        chk("rw_k_raddr", RADDR, 3);
        chk("rw_k_ready", READY, 0);
        @(negedge CLK);
        chk("rw_k1_we", WE, 1);
        chk("rw_k1_waddr", WADDR, 3);
        chk("rw_k1_count", COUNT, 8);
        chk("rw_k1_done", DONE, 0);
        @(negedge CLK);
        chk("rw_k2_done", DONE, 1);
        chk("rw_k2_count", COUNT, 8);
        chk("rw_k2_ready", READY, 1);
        drain();

        // next queue pop must read the advanced read pointer
        exp_q.push_back(ev(1, 4));
        exp_q.push_back(ev(2, 7));
        issue(0, 1, 0, 1);
        drain();

        // flush, then Clr during OPW
        exp_q.push_back(ev(2, 0));
        issue(0, 0, 1, 1);
        drain();
        @(posedge CLK); #2;
        PUSH = 1; MODE = 1;
        @(posedge CLK); #2;
        PUSH = 0;
        chk("mid_state_opw", dbg_state, 1);
        Clr = 1;
        #1;
        chk("mid_we_forced", WE, 0);
        @(posedge CLK); #2;
        Clr = 0;
        @(negedge CLK);
        chk("mid_count", COUNT, 0);
        chk("mid_empty", EMPTY, 1);
        chk("mid_ready", READY, 1);
        chk("mid_done", DONE, 0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
